// File: rtl/cr_prefix_rec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : cr_prefixPKG
// Brief   : Shared types for the prefix recognizer: prefix word/record types
//           and the sequencer state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package cr_prefixPKG;

  // Prefix record produced by the recognizer into the prefix FIFO
  localparam int PREFIX_LEN_W  = 8;
  localparam int PREFIX_CODE_W = 24;
  localparam int PREFIX_W      = PREFIX_LEN_W + PREFIX_CODE_W;

  typedef logic [PREFIX_W-1:0] prefix_word_t;

  typedef struct packed {
    logic [PREFIX_LEN_W-1:0]  len;
    logic [PREFIX_CODE_W-1:0] code;
  } prefix_t;

  // Width of the RUN watchdog timer (matches cfg_timeout)
  localparam int TIMER_W = 16;

  // Sequencer state encoding; values are visible on seq_state for debug
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_FE = 3'd1,
    ST_POP     = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERR     = 3'd5
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/cr_prefix_rec_seq.sv
`default_nettype none
// ============================================================================
// Module  : cr_prefix_rec_seq
// Brief   : Frame sequencer for the prefix recognizer. Waits for all four
//           feature buffers and prefix-FIFO room, pops the buffers, starts
//           the recognizer, then supervises the run with an optional
//           watchdog timer and counts completed frames.
// Rev     : 1.0  initial release
// ============================================================================
module cr_prefix_rec_seq
  import cr_prefixPKG::*;
#(
  parameter int IM_AW = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [IM_AW-1:0] cfg_start_addr,
  input  logic [15:0]      cfg_timeout,
  input  logic             err_clr,
  input  logic [3:0]       fe_ib_empty,
  output logic             seq_fe_rd,
  output logic             seq_start,
  output logic [IM_AW-1:0] seq_start_addr,
  input  logic             rec_done,
  input  logic             pf_afull,
  output logic             seq_hold,
  output logic             seq_busy,
  output logic             seq_err,
  output logic [CNT_W-1:0] seq_frame_cnt,
  output logic [2:0]       seq_state
);

  seq_state_e         state;
  seq_state_e         state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   frame_cnt;
  logic               err;
  logic [IM_AW-1:0]   start_addr;

  logic timer_en;
  logic timer_tick;
  logic timer_expire;

  // The timer only runs in RUN, only when enabled, and freezes while the
  // recognizer is held by prefix-FIFO backpressure. Expiry is the tick that
  // takes the timer to zero (a zero timer is treated as already expired).
  assign timer_en     = (cfg_timeout != '0);
  assign timer_tick   = (state == ST_RUN) && timer_en && !pf_afull;
  assign timer_expire = timer_tick && (timer <= TIMER_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; once a frame is popped it always runs to completion,
  // so cfg_en is only consulted in IDLE, WAIT_FE and at the end of RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_en) state_nxt = ST_WAIT_FE;
      end
      ST_WAIT_FE: begin
        if (!cfg_en) begin
          state_nxt = ST_IDLE;
        end else if ((fe_ib_empty == 4'b0000) && !pf_afull) begin
          state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        state_nxt = ST_START;
      end
      ST_START: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // rec_done wins over a coincident timer expiry
        if (rec_done) begin
          state_nxt = cfg_en ? ST_WAIT_FE : ST_IDLE;
        end else if (timer_expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        if (err_clr) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Timer, frame counter, sticky error and registered start address
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      frame_cnt  <= '0;
      err        <= 1'b0;
      start_addr <= '0;
    end else begin
      // Captured on entry to START so the address output is a pure register
      start_addr <= (state_nxt == ST_START) ? cfg_start_addr : '0;

      if (state == ST_START) begin
        timer <= cfg_timeout;
      end else if (timer_tick && (timer != '0)) begin
        timer <= timer - TIMER_W'(1);
      end

      if ((state == ST_RUN) && rec_done) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end

      if ((state == ST_RUN) && (state_nxt == ST_ERR)) begin
        err <= 1'b1;
      end else if ((state == ST_ERR) && err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // Output decode from registered state; seq_hold is the only input-fed path
  always_comb begin
    seq_fe_rd      = (state == ST_POP);
    seq_start      = (state == ST_START);
    seq_start_addr = start_addr;
    seq_hold       = (state == ST_RUN) && pf_afull;
    seq_busy       = (state != ST_IDLE) && (state != ST_ERR);
    seq_err        = err;
    seq_frame_cnt  = frame_cnt;
    seq_state      = state;
  end

endmodule
`default_nettype wire

// File: tb/tb_cr_prefix_rec_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_cr_prefix_rec_seq
// Brief   : Scoreboard bench for the frame sequencer. Stimulus predicts the
//           cycle and value of each pop / start / count / error event from
//           frame-level timing rules; a monitor checks them as they appear.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cr_prefix_rec_seq;

  localparam int IM_AW = 10;
  localparam int CNT_W = 8;

  localparam int EV_POP   = 0;
  localparam int EV_START = 1;
  localparam int EV_CNT   = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic             clk;
  logic             rst;
  logic             cfg_en;
  logic [IM_AW-1:0] cfg_start_addr;
  logic [15:0]      cfg_timeout;
  logic             err_clr;
  logic [3:0]       fe_ib_empty;
  logic             seq_fe_rd;
  logic             seq_start;
  logic [IM_AW-1:0] seq_start_addr;
  logic             rec_done;
  logic             pf_afull;
  logic             seq_hold;
  logic             seq_busy;
  logic             seq_err;
  logic [CNT_W-1:0] seq_frame_cnt;
  logic [2:0]       seq_state;

  cr_prefix_rec_seq #(.IM_AW(IM_AW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_en         (cfg_en),
    .cfg_start_addr (cfg_start_addr),
    .cfg_timeout    (cfg_timeout),
    .err_clr        (err_clr),
    .fe_ib_empty    (fe_ib_empty),
    .seq_fe_rd      (seq_fe_rd),
    .seq_start      (seq_start),
    .seq_start_addr (seq_start_addr),
    .rec_done       (rec_done),
    .pf_afull       (pf_afull),
    .seq_hold       (seq_hold),
    .seq_busy       (seq_busy),
    .seq_err        (seq_err),
    .seq_frame_cnt  (seq_frame_cnt),
    .seq_state      (seq_state)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  exp_cnt = 0;
  ev_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nonempty();
    logic [3:0] v;
    v = 4'($urandom_range(1, 15));
    return v;
  endfunction

  // Monitor: every observable event must match the head of the scoreboard
  int   last_cnt = 0;
  logic last_err = 1'b0;

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_value", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_cnt = 0;
      last_err = 1'b0;
    end else begin
      if (seq_fe_rd) expect_ev(EV_POP, 0);
      if (seq_start) expect_ev(EV_START, int'(seq_start_addr));
      if (int'(seq_frame_cnt) != last_cnt) begin
        expect_ev(EV_CNT, int'(seq_frame_cnt));
        last_cnt = int'(seq_frame_cnt);
      end
      if (seq_err && !last_err) expect_ev(EV_ERR, 0);
      last_err = seq_err;
    end
  end

  // One frame. mode 0: normal, 1: reset pulsed in RUN, 2: cfg_en dropped in RUN.
  // done_at is the RUN cycle (1-based) carrying rec_done, or -1 for none.
  task automatic frame(input int addr, input int tmo, input int hold_n,
                       input int done_at, input int mode);
    int  k;
    int  ticks;
    bit  h;
    bit  expire;
    bit  finished;
    cfg_start_addr = IM_AW'(addr);
    cfg_timeout    = 16'(tmo);
    fe_ib_empty    = nonempty();
    pf_afull       = 1'b0;
    rec_done       = 1'b0;
    repeat (2 + $urandom_range(0, 2)) step();
    // Buffers ready but prefix FIFO almost full: no pop allowed
    fe_ib_empty = 4'b0000;
    pf_afull    = 1'b1;
    #1;
    chk("hold_outside_run", seq_hold, 0);
    repeat ($urandom_range(1, 3)) step();
    pf_afull = 1'b0;
    k = cyc;
    push(EV_POP, k + 1, 0);
    push(EV_START, k + 2, addr);
    step();
    fe_ib_empty = nonempty();
    step();
    step();
    ticks    = 0;
    finished = 1'b0;
    for (int r = 1; r <= 400; r++) begin
      if (mode == 1 && r == 3) begin
        rst      = 1'b1;
        pf_afull = 1'b0;
        step();
        chk("rst_state", seq_state, 0);
        chk("rst_fe_rd", seq_fe_rd, 0);
        chk("rst_start", seq_start, 0);
        chk("rst_addr", seq_start_addr, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_hold", seq_hold, 0);
        chk("rst_err", seq_err, 0);
        chk("rst_cnt", seq_frame_cnt, 0);
        step();
        rst     = 1'b0;
        exp_cnt = 0;
        return;
      end
      if (mode == 2 && r == 2) cfg_en = 1'b0;
      h        = (r >= 2) && (r < 2 + hold_n);
      pf_afull = h;
      rec_done = (r == done_at);
      #1;
      chk("hold_in_run", seq_hold, h);
      if (r == 1) begin
        chk("run_state", seq_state, 4);
        chk("addr_cleared", seq_start_addr, 0);
      end
      if (tmo != 0 && !h) ticks++;
      expire = (tmo != 0) && (r != done_at) && (ticks == tmo);
      if (r == done_at) begin
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        push(EV_CNT, k + 3 + r, exp_cnt);
      end
      if (expire) push(EV_ERR, k + 3 + r, 0);
      step();
      if (r == done_at || expire) begin
        finished = 1'b1;
        break;
      end
    end
    chk("frame_bounded", finished, 1);
    pf_afull = 1'b0;
    rec_done = 1'b0;
    if (expire) begin
      chk("err_state", seq_state, 5);
      chk("err_busy", seq_busy, 0);
      chk("err_flag", seq_err, 1);
      fe_ib_empty = 4'b0000;
      step();
      step();
      chk("err_holds", seq_state, 5);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_clr_state", seq_state, 0);
      chk("err_clr_flag", seq_err, 0);
      fe_ib_empty = nonempty();
    end else begin
      chk("no_err", seq_err, 0);
      if (mode == 2) begin
        chk("en_drop_idle", seq_state, 0);
        cfg_en = 1'b1;
      end else begin
        chk("done_wait_fe", seq_state, 1);
      end
    end
  endtask

  initial begin
    int tmo;
    int hold_n;
    int done_at;
    rst            = 1'b1;
    cfg_en         = 1'b0;
    cfg_start_addr = '0;
    cfg_timeout    = '0;
    err_clr        = 1'b0;
    fe_ib_empty    = 4'b1111;
    rec_done       = 1'b0;
    pf_afull       = 1'b0;
    repeat (3) step();
    chk("reset_state", seq_state, 0);
    chk("reset_cnt", seq_frame_cnt, 0);
    chk("reset_busy", seq_busy, 0);
    chk("reset_err", seq_err, 0);
    chk("reset_start", seq_start, 0);
    rst    = 1'b0;
    step();
    chk("idle_without_en", seq_state, 0);
    cfg_en = 1'b1;

    frame(10'h155, 0, 0, 3, 0);     // basic pop/start latency
    frame(10'h02A, 30, 5, 10, 0);   // backpressure hold in RUN
    frame(10'h003, 20, 0, -1, 0);   // timeout after 20 RUN cycles
    frame(10'h3FF, 12, 4, -1, 0);   // timeout extended by frozen cycles
    frame(10'h100, 15, 0, 15, 0);   // done coincides with expiry
    frame(10'h0F0, 10, 3, 13, 0);   // coincide with hold
    frame(10'h201, 0, 1, 6, 2);     // cfg_en dropped mid-frame
    frame(10'h111, 25, 2, 8, 0);
    frame(10'h222, 0, 0, -1, 1);    // reset during RUN
    frame(10'h333, 9, 0, 4, 0);

    for (int i = 0; i < 30; i++) begin
      tmo     = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(4, 30);
      hold_n  = $urandom_range(0, 4);
      if (tmo == 0) done_at = $urandom_range(1, 12);
      else if ($urandom_range(0, 3) == 0) done_at = -1;
      else done_at = $urandom_range(1, tmo + hold_n);
      frame($urandom_range(0, (1 << IM_AW) - 1), tmo, hold_n, done_at,
            ($urandom_range(0, 5) == 0 && done_at >= 2) ? 2 : 0);
    end

    // Enough frames to wrap the counter at least once
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      frame($urandom_range(0, (1 << IM_AW) - 1), 0, 0, 1, 0);
    end

    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cr_prefix_rec_seq.md
CR_PREFIX_REC_SEQ -- requirements
Module: cr_prefix_rec_seq

Interface
REQ-001 SHALL have parameter IM_AW, default 10: instruction-memory address width.
REQ-002 SHALL have parameter CNT_W, default 16: frame-counter width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_en, input, 1: sequencer enable.
REQ-006 SHALL have port cfg_start_addr, input, IM_AW: program entry address.
REQ-007 SHALL have port cfg_timeout, input, 16: RUN cycle limit; 0 disables the timeout.
REQ-008 SHALL have port err_clr, input, 1: single-cycle pulse that clears the error.
REQ-009 SHALL have port fe_ib_empty, input, 4: empty flags of feature buffers 1..4, bit0 = buffer 1.
REQ-010 SHALL have port seq_fe_rd, output, 1: single-cycle pop of all four feature buffers.
REQ-011 SHALL have port seq_start, output, 1: recognizer start pulse.
REQ-012 SHALL have port seq_start_addr, output, IM_AW: entry address, valid while seq_start is high.
REQ-013 SHALL have port rec_done, input, 1: recognizer finished the frame and pushed its prefix.
REQ-014 SHALL have port pf_afull, input, 1: prefix FIFO almost full.
REQ-015 SHALL have port seq_hold, output, 1: recognizer pipeline hold.
REQ-016 SHALL have port seq_busy, output, 1: high in any state other than IDLE or ERR.
REQ-017 SHALL have port seq_err, output, 1: sticky timeout error.
REQ-018 SHALL have port seq_frame_cnt, output, CNT_W: count of completed frames.
REQ-019 SHALL have port seq_state, output, 3: current state encoding, for debug.

Function
REQ-020 SHALL implement FSM states IDLE=0, WAIT_FE=1, POP=2, START=3, RUN=4, ERR=5.
REQ-021 SHALL decode all outputs from registered state or registered counters only; no combinational input-to-output path except seq_hold (see REQ-028).
REQ-022 SHALL transition IDLE -> WAIT_FE on the cycle after cfg_en is sampled high.
REQ-023 SHALL transition WAIT_FE -> POP when fe_ib_empty==4'b0000 and pf_afull==0; SHALL transition WAIT_FE -> IDLE when cfg_en==0; the enable check takes priority.
REQ-024 SHALL assert seq_fe_rd for exactly the one POP cycle, then go to START; first seq_fe_rd is one cycle after the qualifying WAIT_FE sample.
REQ-025 SHALL assert seq_start for exactly the one START cycle, drive seq_start_addr=cfg_start_addr (0 otherwise), load the timer with cfg_timeout, and then go to RUN.
REQ-026 In RUN, rec_done SHALL increment seq_frame_cnt (modulo 2^CNT_W, wraps) and go to WAIT_FE, or to IDLE if cfg_en==0.
REQ-027 In RUN with cfg_timeout!=0, the timer SHALL decrement each cycle seq_hold==0; if the timer reaches 0 without rec_done, the FSM SHALL go to ERR and set seq_err.
REQ-028 SHALL drive seq_hold = pf_afull when in RUN, and 0 in all other states.
REQ-029 When rec_done and timer expiry coincide, done SHALL win: count incremented, no error.
REQ-030 SHALL ignore rec_done outside RUN.
REQ-031 In ERR, the FSM SHALL hold and issue no pops or starts; err_clr SHALL clear seq_err and go to IDLE.
REQ-032 Deasserting cfg_en in POP, START or RUN SHALL NOT abort the frame; the frame completes first.

Reset
REQ-033 While rst is high, state SHALL be IDLE, the timer and seq_frame_cnt 0, seq_err 0, and all outputs 0; reset SHALL override any in-flight frame with no pop or start issued on the cycle after.
REQ-034 Operation SHALL resume from IDLE on the first cycle after rst deasserts.

Structure
REQ-035 The state enum (seq_state_e) SHALL live in cr_prefixPKG, alongside the existing prefix typedefs.
REQ-036 SHALL be one flat module with no sub-module; the timer and counter are inline (target 150-250 RTL lines).

Verification
REQ-037 Scenario: cfg_en=1, empty 4'b1111 then 4'b0000 at cycle 10 -> seq_fe_rd at cycle 11, seq_start with addr=cfg_start_addr at 12, seq_state=4 at 13.
REQ-038 Scenario: fe_ib_empty=4'b0000 with pf_afull=1 -> no pop; pf_afull drops -> pop one cycle later; in RUN, pf_afull=1 for 5 cycles -> seq_hold high for exactly 5 cycles and the timer frozen.
REQ-039 Scenario: cfg_timeout=20 and no rec_done -> ERR entered 20 RUN cycles after START, seq_err=1; err_clr -> IDLE, seq_err=0.
REQ-040 Scenario: rec_done on the same cycle the timer expires -> seq_frame_cnt +1 and seq_err=0; 65536 frames -> seq_frame_cnt wraps to 0.
REQ-041 Scenario: rst pulsed during RUN -> all outputs 0 on the next cycle; cfg_en dropped during RUN -> the frame completes, then IDLE.
